// File: rtl/tff_pkg.sv
// Shared types and defaults for the tff_bank toggle flip-flop bank.
package tff_pkg;

   typedef enum logic [1:0] {
      MODE_LEVEL = 2'b00,
      MODE_EDGE  = 2'b01,
      MODE_COUNT = 2'b10,
      MODE_HOLD  = 2'b11
   } tff_mode_e;

   localparam int         TFF_DEF_CHANNELS = 8;
   localparam int         TFF_DEF_SYNC     = 2;
   localparam logic [7:0] TFF_EVT_MAX      = 8'hFF;

endpackage

// File: rtl/tff_sync_edge.sv
// Per-channel synchroniser for an asynchronous toggle request plus a rising-edge detector.
module tff_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_async,
   output logic sync_o,
   output logic rise_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   t_prev;

   // t_prev runs every cycle so a mode switch never manufactures an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         t_prev <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_async};
         t_prev <= sync_q[SYNC_STAGES-1];
      end
   end

   assign sync_o = sync_q[SYNC_STAGES-1];
   assign rise_o = sync_o & ~t_prev;

endmodule

// File: rtl/tff_bank.sv
// Bank of toggle flip-flops with LEVEL/EDGE/COUNT/HOLD modes, clear, load and event/wrap strobes.
// Optional saturating event counter on evt_count is built when TFF_EVENT_CNT_EN is defined.
module tff_bank
   import tff_pkg::*;
#(
   parameter int CHANNELS    = TFF_DEF_CHANNELS,
   parameter int SYNC_STAGES = TFF_DEF_SYNC
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ena,
   input  logic [CHANNELS-1:0] t_in,
   input  logic [1:0]          mode,
   input  logic                clr,
   input  logic                load,
   input  logic [CHANNELS-1:0] load_val,
   output logic [CHANNELS-1:0] q,
   output logic                event_o,
   output logic                wrap_o,
   output logic [7:0]          evt_count
);

   logic [CHANNELS-1:0] t_sync;
   logic [CHANNELS-1:0] rise;
   logic [CHANNELS-1:0] q_next;
   logic                event_next;
   logic                wrap_next;
   tff_mode_e           mode_e;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_sync
      tff_sync_edge #(
         .SYNC_STAGES(SYNC_STAGES)
      ) u_sync (
         .clk    (clk),
         .rst_n  (rst_n),
         .d_async(t_in[i]),
         .sync_o (t_sync[i]),
         .rise_o (rise[i])
      );
   end

   assign mode_e = tff_mode_e'(mode);

   // Priority: clr over load over ena over the mode operation.
   always_comb begin
      q_next     = q;
      event_next = 1'b0;
      wrap_next  = 1'b0;
      if (clr) begin
         q_next = '0;
      end else if (load) begin
         q_next = load_val;
      end else if (ena) begin
         case (mode_e)
            MODE_LEVEL: q_next = q ^ t_sync;
            MODE_EDGE:  q_next = q ^ rise;
            MODE_COUNT: begin
               if (rise[0]) begin
                  q_next    = q + CHANNELS'(1);
                  wrap_next = &q;
               end
            end
            default:    q_next = q;
         endcase
         event_next = (q_next != q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q       <= '0;
         event_o <= 1'b0;
         wrap_o  <= 1'b0;
      end else begin
         q       <= q_next;
         event_o <= event_next;
         wrap_o  <= wrap_next;
      end
   end

`ifdef TFF_EVENT_CNT_EN
   logic [7:0] evt_cnt_q;

   // Load leaves the count alone; only reset and clr zero it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         evt_cnt_q <= 8'h00;
      end else if (clr) begin
         evt_cnt_q <= 8'h00;
      end else if (event_o && (evt_cnt_q != TFF_EVT_MAX)) begin
         evt_cnt_q <= evt_cnt_q + 8'd1;
      end
   end

   assign evt_count = evt_cnt_q;
`else
   assign evt_count = 8'h00;
`endif

endmodule

// File: doc/tff_bank.md
Name: tff_bank

Overview:
- Parametrised successor to the single T flip-flop project: a bank of CHANNELS toggle flip-flops with selectable mode (level toggle, edge toggle, binary counter, hold).
- Asynchronous t_in bits pass through per-channel synchronisers and rising-edge detectors.
- Synchronous clear and load are provided, plus event and wrap strobes.
- Sits as the core under the Tiny Tapeout top wrapper, which maps ui_in/uio_in onto t_in/mode/controls and q onto uo_out.

Parameters:
- CHANNELS, 8, number of flip-flops / width of t_in, q and load_val (1..16).
- SYNC_STAGES, 2, synchroniser depth per t_in bit (2..4).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  operation enable; 0 freezes q (synchronisers keep running).
- t_in  input  CHANNELS  asynchronous toggle requests.
- mode  input  2  00 LEVEL, 01 EDGE, 10 COUNT, 11 HOLD.
- clr  input  1  synchronous clear of q.
- load  input  1  synchronous parallel load.
- load_val  input  CHANNELS  value written by load.
- q  output  CHANNELS  flip-flop states.
- event_o  output  1  one-cycle pulse when q changed by mode operation.
- wrap_o  output  1  one-cycle pulse on COUNT wrap from all-ones to 0.
- evt_count  output  8  saturating event counter; present only with the optional feature.

Behaviour:
- Reset: asynchronous on rst_n=0; registered on clk rising edge otherwise.
  - Outputs: q=0, event_o=0, wrap_o=0, evt_count=0.
  - Internal state: all synchroniser flops and t_prev=0.
- Synchroniser and edge detect:
  - t_sync = t_in after SYNC_STAGES flops.
  - t_prev registers t_sync every cycle, regardless of ena, clr, load or mode.
  - rise = t_sync & ~t_prev.
- Latency: t_in goes high before edge 1 -> t_sync high after edge SYNC_STAGES -> q changes at edge SYNC_STAGES+1.
- Priority per cycle: clr > load > ena=0 > mode.
  - clr=1: q<=0; event_o=0, wrap_o=0.
  - load=1: q<=load_val; event_o=0, wrap_o=0.
  - ena=0: q holds; strobes 0. Edges arriving while ena=0 are consumed, not queued.
- LEVEL: q[i] toggles every cycle while t_sync[i]=1.
- EDGE: q[i] toggles once per rise[i].
- COUNT:
  - q treated as an unsigned CHANNELS-bit counter; +1 per rise[0]; t_in[CHANNELS-1:1] ignored.
  - All-ones +1 -> 0 with wrap_o=1 in the same cycle q becomes 0.
- HOLD: q holds; strobes 0.
- event_o=1 in the cycle after an edge that changed q through LEVEL, EDGE or COUNT. It is registered, aligned with the new q.
- Mode change: takes effect at the next edge. t_prev continuity guarantees no spurious edge on a mode switch.
- Reset mid-operation: everything returns to reset values immediately. After release, t_in already high produces a rise after SYNC_STAGES+1 edges, because t_prev resets to 0.

Optional Feature:
- Macro: TFF_EVENT_CNT_EN.
- Defined:
  - evt_count increments by 1 each cycle event_o is asserted.
  - Saturates at 255.
  - Cleared by rst_n and by clr; load does not affect it.
- Undefined: the counter flops are not built and evt_count is tied to 8'h00. The port list is unchanged.

Decomposition:
- Package tff_pkg:
  - typedef tff_mode_e (MODE_LEVEL=2'b00, MODE_EDGE=2'b01, MODE_COUNT=2'b10, MODE_HOLD=2'b11).
  - Constants TFF_DEF_CHANNELS=8, TFF_DEF_SYNC=2, TFF_EVT_MAX=8'hFF.
- Sub-module tff_sync_edge:
  - One per channel, via generate.
  - Parameter SYNC_STAGES; ports clk, rst_n, d_async, sync_o, rise_o.
  - Top-level holds q, the mode mux, strobes and the optional counter.

Test Plan (CHANNELS=8, SYNC_STAGES=2):
- Reset: drive t_in=8'hFF, mode=01, then assert rst_n=0 mid-stream -> q=8'h00, event_o=0, wrap_o=0 immediately. Release: q=8'hFF at the 3rd edge.
- EDGE: pulse t_in[3] high 5 cycles, low, then high again -> q=8'h08 after the first pulse (3 edges latency), q=8'h00 after the second; event_o exactly two single-cycle pulses.
- LEVEL: hold t_in[0]=1 for 6 cycles after sync -> q[0] alternates 1,0,1,0,1,0; event_o high 6 cycles.
- COUNT: load 8'hFD, then 3 rises on t_in[0] -> q=FE, FF, 00. wrap_o pulses once, coincident with q=00.
- Priority and ena:
  - clr=1 and load=1 with load_val=8'hA5 -> q=8'h00.
  - ena=0 during a t_in[1] rise -> q unchanged, and no toggle after ena returns to 1.
  - Switching mode 01->11->01 with t_in steady high -> no toggle.
- TFF_EVENT_CNT_EN defined:
  - 300 EDGE toggles -> evt_count=255 (saturated); clr -> 0.
  - Undefined build: evt_count=0 throughout.
